// File: rtl/fyp_eth_pkg.sv
// Shared types and constants for the fyp Ethernet receive path: FSM states,
// broadcast address, default length limits and TSE MAC error-flag positions.
package fyp_eth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } rx_state_e;

  localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;
  localparam int          ETH_MIN_LEN = 64;
  localparam int          ETH_MAX_LEN = 1518;

  // Bit positions inside eth_ast_rx_err
  localparam int ERR_BIT_ANY       = 0;
  localparam int ERR_BIT_LEN       = 1;
  localparam int ERR_BIT_CRC       = 2;
  localparam int ERR_BIT_TRUNC     = 3;
  localparam int ERR_BIT_PHY       = 4;
  localparam int ERR_BIT_COLLISION = 5;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    else return v + 16'd1;
  endfunction

endpackage

// File: rtl/fyp_sat_counter.sv
// Saturating up-counter with synchronous clear; the increment is a variable
// amount so the same block serves frame counters and the byte counter.
module fyp_sat_counter #(
  parameter int W     = 32,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc_en,
  input  logic [INC_W-1:0] inc_val,
  output logic [W-1:0]     count
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;
  logic [W:0]   sum_s;

  // Next count: clear beats increment, overflow pins the value at all-ones
  always_comb begin
    sum_s = {1'b0, cnt_r} + {{(W + 1 - INC_W){1'b0}}, inc_val};
    if (clr) cnt_nxt_s = {W{1'b0}};
    else if (!inc_en) cnt_nxt_s = cnt_r;
    else if (sum_s[W]) cnt_nxt_s = {W{1'b1}};
    else cnt_nxt_s = sum_s[W-1:0];
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_r <= {W{1'b0}};
    else cnt_r <= cnt_nxt_s;
  end

  assign count = cnt_r;

endmodule

// File: rtl/fyp_reception.sv
// Avalon-ST sink for the TSE MAC receive interface: classifies frames and keeps
// saturating statistics. Define FYP_RX_PAYLOAD_CHECK_EN for the payload sequence check.
module fyp_reception
  import fyp_eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC     = 48'h00_1C_23_17_4A_CB,
  parameter int          FILTER_ENABLE = 1,
  parameter int          MIN_LEN       = ETH_MIN_LEN,
  parameter int          MAX_LEN       = ETH_MAX_LEN,
  parameter int          CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cnt_clr,
  input  logic [31:0]      eth_ast_rx_data,
  input  logic             eth_ast_rx_sop,
  input  logic             eth_ast_rx_eop,
  input  logic [1:0]       eth_ast_rx_empty,
  input  logic [5:0]       eth_ast_rx_err,
  input  logic             eth_ast_rx_valid,
  output logic             eth_ast_rx_rdy,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [15:0]      last_len,
`ifdef FYP_RX_PAYLOAD_CHECK_EN
  output logic [CNT_W-1:0] seq_err_cnt,
`endif
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] filt_cnt,
  output logic [CNT_W-1:0] proto_cnt,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam logic [17:0] MIN_LEN_C = 18'(MIN_LEN);
  localparam logic [17:0] MAX_LEN_C = 18'(MAX_LEN);

  rx_state_e   state_r, state_nxt_s;
  logic        rdy_r;
  logic [15:0] words_r;
  logic [31:0] dst_hi_r;
  logic        filter_hit_r;
  logic        frame_done_r;
  logic        frame_ok_r;
  logic [15:0] last_len_r;

  logic        accept_s, frame_beat_s, orphan_s, abandon_s, close_s;
  logic [15:0] words_s;
  logic [17:0] len_s;
  logic [47:0] dst_s;
  logic        hit_now_s, frame_err_s, seq_bad_s;
  logic        good_inc_s, err_inc_s, filt_inc_s, proto_inc_s;

  // A beat belongs to a frame when it carries sop or arrives mid-frame
  assign accept_s     = eth_ast_rx_valid & rdy_r;
  assign frame_beat_s = accept_s & (eth_ast_rx_sop | (state_r != IDLE));
  assign orphan_s     = accept_s & ~eth_ast_rx_sop & (state_r == IDLE);
  assign abandon_s    = accept_s & eth_ast_rx_sop & (state_r != IDLE);
  assign close_s      = frame_beat_s & eth_ast_rx_eop;
  assign words_s      = eth_ast_rx_sop ? 16'd1 : sat_inc16(words_r);
  assign len_s        = {words_s, 2'b00} - {16'd0, eth_ast_rx_empty};
  assign dst_s        = {dst_hi_r, eth_ast_rx_data[31:16]};

  // Destination match; a frame closing on word 0 is treated as a hit
  always_comb begin
    hit_now_s = filter_hit_r;
    if (eth_ast_rx_sop) begin
      hit_now_s = 1'b1;
    end else begin
      case (state_r)
        HDR:     hit_now_s = (FILTER_ENABLE == 0) || (dst_s == LOCAL_MAC) || (dst_s == BCAST_MAC);
        default: hit_now_s = filter_hit_r;
      endcase
    end
  end

  assign frame_err_s = (eth_ast_rx_err != 6'd0) || (len_s < MIN_LEN_C) || (len_s > MAX_LEN_C) || seq_bad_s;
  assign err_inc_s   = close_s & frame_err_s;
  assign filt_inc_s  = close_s & ~frame_err_s & ~hit_now_s;
  assign good_inc_s  = close_s & ~frame_err_s & hit_now_s;
  assign proto_inc_s = orphan_s | abandon_s;

  // Next-state logic; a restarting sop re-enters HDR
  always_comb begin
    state_nxt_s = state_r;
    if (frame_beat_s) begin
      if (eth_ast_rx_eop) state_nxt_s = IDLE;
      else if (eth_ast_rx_sop) state_nxt_s = HDR;
      else state_nxt_s = PAYLOAD;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else state_r <= state_nxt_s;
  end

  // Frame tracking and per-frame result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_r        <= 1'b0;
      words_r      <= 16'd0;
      dst_hi_r     <= 32'd0;
      filter_hit_r <= 1'b0;
      frame_done_r <= 1'b0;
      frame_ok_r   <= 1'b0;
      last_len_r   <= 16'd0;
    end else begin
      rdy_r        <= 1'b1;
      frame_done_r <= close_s;
      if (frame_beat_s) begin
        words_r      <= words_s;
        filter_hit_r <= hit_now_s;
      end
      if (accept_s && eth_ast_rx_sop) dst_hi_r <= eth_ast_rx_data;
      if (close_s) begin
        frame_ok_r <= ~frame_err_s & hit_now_s;
        last_len_r <= len_s[15:0];
      end
    end
  end

`ifdef FYP_RX_PAYLOAD_CHECK_EN
  logic [31:0] seq_exp_r;
  logic        seq_bad_r;
  logic [31:0] seq_mask_s;
  logic        seq_miss_s;

  // Word 4 seeds the sequence; later words must follow it, ignoring empty bytes
  always_comb begin
    seq_mask_s = eth_ast_rx_eop ? (32'hFFFF_FFFF << {eth_ast_rx_empty, 3'b000}) : 32'hFFFF_FFFF;
    seq_miss_s = frame_beat_s && !eth_ast_rx_sop && (words_s > 16'd5) &&
                 (((eth_ast_rx_data ^ seq_exp_r) & seq_mask_s) != 32'd0);
    seq_bad_s  = (eth_ast_rx_sop ? 1'b0 : seq_bad_r) | seq_miss_s;
  end

  // Expected sequence word and sticky mismatch flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_exp_r <= 32'd0;
      seq_bad_r <= 1'b0;
    end else if (frame_beat_s) begin
      seq_bad_r <= seq_bad_s;
      if (words_s == 16'd5) seq_exp_r <= eth_ast_rx_data + 32'd1;
      else if (words_s > 16'd5) seq_exp_r <= seq_exp_r + 32'd1;
    end
  end

  fyp_sat_counter #(.W(CNT_W), .INC_W(1)) u_seq_err_cnt (
    .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc_en(close_s & seq_bad_s),
    .inc_val(1'b1), .count(seq_err_cnt));
`else
  assign seq_bad_s = 1'b0;
`endif

  fyp_sat_counter #(.W(CNT_W), .INC_W(1)) u_good_cnt (
    .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc_en(good_inc_s),
    .inc_val(1'b1), .count(good_cnt));
  fyp_sat_counter #(.W(CNT_W), .INC_W(1)) u_err_cnt (
    .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc_en(err_inc_s),
    .inc_val(1'b1), .count(err_cnt));
  fyp_sat_counter #(.W(CNT_W), .INC_W(1)) u_filt_cnt (
    .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc_en(filt_inc_s),
    .inc_val(1'b1), .count(filt_cnt));
  fyp_sat_counter #(.W(CNT_W), .INC_W(1)) u_proto_cnt (
    .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc_en(proto_inc_s),
    .inc_val(1'b1), .count(proto_cnt));
  fyp_sat_counter #(.W(CNT_W), .INC_W(18)) u_byte_cnt (
    .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc_en(good_inc_s),
    .inc_val(len_s), .count(byte_cnt));

  assign eth_ast_rx_rdy = rdy_r;
  assign frame_done     = frame_done_r;
  assign frame_ok       = frame_ok_r;
  assign last_len       = last_len_r;

endmodule

// File: tb/tb_fyp_reception.sv
// Randomised scoreboard bench for fyp_reception: stimulus pushes expected frame
// results computed from the frame-level rules, a monitor pops them on frame_done.
module tb_fyp_reception;
  import fyp_eth_pkg::*;

  localparam logic [47:0] LOCAL_MAC = 48'h00_1C_23_17_4A_CB;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_01;
  localparam longint      SAT       = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [31:0] rx_data = 32'd0;
  logic        rx_sop = 1'b0, rx_eop = 1'b0, rx_valid = 1'b0;
  logic [1:0]  rx_empty = 2'd0;
  logic [5:0]  rx_err = 6'd0;
  logic        rx_rdy, frame_done, frame_ok;
  logic [15:0] last_len;
  logic [31:0] good_cnt, err_cnt, filt_cnt, proto_cnt, byte_cnt;
`ifdef FYP_RX_PAYLOAD_CHECK_EN
  logic [31:0] seq_err_cnt;
`endif

  fyp_reception dut (
    .clk(clk), .reset_n(reset_n), .cnt_clr(cnt_clr),
    .eth_ast_rx_data(rx_data), .eth_ast_rx_sop(rx_sop), .eth_ast_rx_eop(rx_eop),
    .eth_ast_rx_empty(rx_empty), .eth_ast_rx_err(rx_err), .eth_ast_rx_valid(rx_valid),
    .eth_ast_rx_rdy(rx_rdy), .frame_done(frame_done), .frame_ok(frame_ok),
    .last_len(last_len),
`ifdef FYP_RX_PAYLOAD_CHECK_EN
    .seq_err_cnt(seq_err_cnt),
`endif
    .good_cnt(good_cnt), .err_cnt(err_cnt), .filt_cnt(filt_cnt),
    .proto_cnt(proto_cnt), .byte_cnt(byte_cnt));

  always #4 clk = ~clk;

  typedef struct {
    longint due;
    logic   ok;
    longint len, good, err, filt, proto, bytes;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  longint cyc = 0;
  longint m_good = 0, m_err = 0, m_filt = 0, m_proto = 0, m_bytes = 0;
  int     checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Frame-level reference: classify by length, MAC error and destination
  task automatic model_close(input int nwords, input logic [1:0] empty, input logic [47:0] dst,
                             input logic [5:0] err, input bit clr);
    exp_t   e;
    longint len = 4 * nwords - empty;
    bit     hit = (nwords < 2) || (dst == LOCAL_MAC) || (dst == BCAST_MAC);
    bit     bad = (err != 6'd0) || (len < 64) || (len > 1518);
    if (bad) m_err = sat(m_err + 1);
    else if (!hit) m_filt = sat(m_filt + 1);
    else begin
      m_good  = sat(m_good + 1);
      m_bytes = sat(m_bytes + len);
    end
    if (clr) begin
      m_good = 0; m_err = 0; m_filt = 0; m_proto = 0; m_bytes = 0;
    end
    e.due = cyc + 1; e.ok = !bad && hit; e.len = len & 64'hFFFF;
    e.good = m_good; e.err = m_err; e.filt = m_filt; e.proto = m_proto; e.bytes = m_bytes;
    sb_q.push_back(e);
  endtask

  task automatic idle_beat();
    rx_valid = 1'b0;
    rx_sop = 1'($urandom); rx_eop = 1'($urandom);
    rx_empty = 2'($urandom); rx_err = 6'($urandom); rx_data = $urandom;
  endtask

  // Drives nbeats beats of a frame; eop only on the last when do_eop is set
  task automatic send_beats(input int nbeats, input logic [1:0] empty, input logic [47:0] dst,
                            input logic [5:0] err, input bit gaps, input bit clr, input bit do_eop);
    logic [31:0] seed = $urandom;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        idle_beat();
        cnt_clr = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_sop   = (i == 0);
      rx_eop   = do_eop && (i == nbeats - 1);
      rx_empty = rx_eop ? empty : 2'($urandom);
      rx_err   = rx_eop ? err : 6'($urandom);
      if (i == 0) rx_data = dst[47:16];
      else if (i == 1) rx_data = {dst[15:0], 16'h0800};
      else if (i >= 4) rx_data = seed + 32'(i - 4);
      else rx_data = $urandom;
      cnt_clr = rx_eop && clr;
      if (rx_eop) model_close(nbeats, empty, dst, err, clr);
    end
    @(negedge clk);
    idle_beat();
    cnt_clr = 1'b0;
  endtask

  task automatic send_frame(input int nwords, input logic [1:0] empty, input logic [47:0] dst,
                            input logic [5:0] err, input bit gaps, input bit clr);
    send_beats(nwords, empty, dst, err, gaps, clr, 1'b1);
  endtask

  task automatic send_orphan();
    @(negedge clk);
    rx_valid = 1'b1; rx_sop = 1'b0; rx_eop = 1'($urandom); rx_data = $urandom;
    m_proto = sat(m_proto + 1);
    @(negedge clk);
    idle_beat();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_good_cnt"},  good_cnt,  m_good);
    check({tag, "_err_cnt"},   err_cnt,   m_err);
    check({tag, "_filt_cnt"},  filt_cnt,  m_filt);
    check({tag, "_proto_cnt"}, proto_cnt, m_proto);
    check({tag, "_byte_cnt"},  byte_cnt,  m_bytes);
  endtask

  // Scoreboard monitor: every frame_done must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n && frame_done) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame_done: got frame_done=1, expected none (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("frame_done_latency", cyc, mon_e.due);
        check("frame_ok",  frame_ok,  mon_e.ok);
        check("last_len",  last_len,  mon_e.len);
        check("good_cnt",  good_cnt,  mon_e.good);
        check("err_cnt",   err_cnt,   mon_e.err);
        check("filt_cnt",  filt_cnt,  mon_e.filt);
        check("proto_cnt", proto_cnt, mon_e.proto);
        check("byte_cnt",  byte_cnt,  mon_e.bytes);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] dst;
    logic [5:0]  err;
    int          nw;

    repeat (3) @(negedge clk);
    check("reset_rdy", rx_rdy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_last_len", last_len, 0);
    check_counters("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("rdy_after_reset", rx_rdy, 1);

    send_frame(16, 2'd0, LOCAL_MAC, 6'd0, 1'b0, 1'b0);
    send_frame(380, 2'd2, LOCAL_MAC, 6'd0, 1'b0, 1'b0);
    send_frame(380, 2'd1, LOCAL_MAC, 6'd0, 1'b0, 1'b0);
    send_frame(16, 2'd0, OTHER_MAC, 6'd0, 1'b0, 1'b0);
    send_frame(16, 2'd0, BCAST_MAC, 6'd0, 1'b0, 1'b0);

    send_beats(5, 2'd0, LOCAL_MAC, 6'd0, 1'b0, 1'b0, 1'b0);
    m_proto = sat(m_proto + 1);
    send_frame(16, 2'd0, LOCAL_MAC, 6'd0, 1'b0, 1'b0);
    send_orphan();

    send_frame(1, 2'd0, LOCAL_MAC, 6'd0, 1'b0, 1'b0);
    send_frame(25, 2'd0, LOCAL_MAC, 6'h02, 1'b0, 1'b0);

    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 2))
        0:       dst = LOCAL_MAC;
        1:       dst = BCAST_MAC;
        default: dst = {16'h0200, 32'($urandom)};
      endcase
      case ($urandom_range(0, 9))
        0:       nw = $urandom_range(1, 15);
        1:       nw = $urandom_range(378, 400);
        default: nw = $urandom_range(16, 60);
      endcase
      err = ($urandom_range(0, 7) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
      if ($urandom_range(0, 5) == 0) begin
        send_beats($urandom_range(1, 8), 2'd0, dst, 6'd0, 1'b1, 1'b0, 1'b0);
        m_proto = sat(m_proto + 1);
      end
      send_frame(nw, 2'($urandom), dst, err, 1'b1, $urandom_range(0, 14) == 0);
      if ($urandom_range(0, 4) == 0) send_orphan();
    end

    repeat (3) @(negedge clk);
    force dut.u_good_cnt.cnt_r = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.u_good_cnt.cnt_r;
    m_good = SAT;
    @(negedge clk);
    check("good_cnt_forced", good_cnt, SAT);
    send_frame(16, 2'd0, LOCAL_MAC, 6'd0, 1'b0, 1'b0);

    send_frame(16, 2'd0, LOCAL_MAC, 6'd0, 1'b0, 1'b1);
    send_frame(16, 2'd0, LOCAL_MAC, 6'd0, 1'b0, 1'b0);

    send_beats(6, 2'd0, LOCAL_MAC, 6'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midreset_rdy", rx_rdy, 0);
    check("midreset_frame_ok", frame_ok, 0);
    check("midreset_last_len", last_len, 0);
    m_good = 0; m_err = 0; m_filt = 0; m_proto = 0; m_bytes = 0;
    check_counters("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rdy_after_midreset", rx_rdy, 1);
    send_frame(16, 2'd0, LOCAL_MAC, 6'd0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check_counters("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
